timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, the clk frequency; the prescaler terminal count is CLK_HZ-1.
REQ-002 SHALL have parameter MAX_ADDS, default 20, the maximum lap (+30 s) pulses accepted per round.
REQ-003 SHALL have parameter ALARM_SECS, default 3, the alarm duration in seconds after expiry.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-005 SHALL have port nrst, input, 1, a synchronous active-low reset.
REQ-006 SHALL have port start_btn, input, 1, start/confirm button, already synchronized to clk.
REQ-007 SHALL have port add_btn, input, 1, add-time button, synchronized.
REQ-008 SHALL have port pause_btn, input, 1, pause/resume button, synchronized; present only under the macro (REQ-030).
REQ-009 SHALL have port rst_btn, input, 1, abort-round button, synchronized.
REQ-010 SHALL have port time_up, input, 1, the expiry flag from the countdown timer.
REQ-011 SHALL have port enable_dec, output, 1, a level that enables timer countdown.
REQ-012 SHALL have port enable_in, output, 1, a level that enables timer increment.
REQ-013 SHALL have port clk_div, output, 1, a one-cycle 1 Hz decrement strobe.
REQ-014 SHALL have port lap, output, 1, a one-cycle add-30 pulse.
REQ-015 SHALL have port clear, output, 1, a level that clears the timer.
REQ-016 SHALL have port state, output, 3, the current FSM state code.
REQ-017 SHALL have port alarm, output, 1, the expiry alarm level.

Function
REQ-018 SHALL rising-edge detect every button with one history register; an edge sampled in cycle N acts in cycle N+1.
REQ-019 SHALL register all outputs, which change one cycle after the causing state or edge.
REQ-020 SHALL implement these states:
- IDLE = 0: clear = 1; start edge -> SET, with add_count = 0.
- SET = 1: enable_in = 1.
  - Add edge with add_count < MAX_ADDS: one lap pulse, add_count+1.
  - Add edge at MAX_ADDS: ignored.
  - Start edge with add_count > 0: -> RUN.
  - Start edge with add_count = 0: ignored.
- RUN = 2: enable_dec = 1; clk_div pulses for one cycle when the prescaler equals CLK_HZ-1; time_up = 1 -> DONE.
- PAUSE = 3: enable_dec = 0; prescaler holds its value.
- DONE = 4: enable_dec = enable_in = 0.
  - alarm = 1 until ALARM_SECS prescaler terminal counts have elapsed, then 0.
  - Start edge -> IDLE.
REQ-021 SHALL make the prescaler count 0..CLK_HZ-1 and wrap to 0; it is zeroed on SET->RUN and on entry to DONE, and advances only in RUN and DONE.
REQ-022 SHALL give rst_btn edge priority over everything: any state -> IDLE, add_count cleared, alarm cleared, prescaler zeroed.
REQ-023 SHALL apply priority rst_btn > time_up > pause > start/add when events coincide in one cycle; time_up in RUN together with a pause edge goes to DONE.
REQ-024 SHALL ignore time_up outside RUN, and SHALL not issue clk_div in the cycle RUN exits.
REQ-025 SHALL return any unused state code to IDLE on the next cycle.

Reset
REQ-026 SHALL, with nrst low at a rising clk edge, set state = IDLE and zero add_count, the prescaler, the alarm counter and all button history registers.
REQ-027 SHALL hold outputs after reset at clear = 1, and enable_dec = enable_in = clk_div = lap = alarm = 0.
REQ-028 SHALL treat reset asserted mid-RUN or mid-DONE the same as power-up, with no strobe or lap emitted in that cycle.
REQ-029 SHALL not treat a button held high through reset release as an edge.

Configuration
REQ-030 SHALL use macro TIMER_CTRL_PAUSE_EN to control pause:
- Defined: pause_btn and the PAUSE state exist; a pause edge in RUN -> PAUSE, and a pause edge in PAUSE -> RUN resuming the held prescaler.
- Undefined: no pause_btn port, PAUSE is unreachable, and code 3 is treated as illegal per REQ-025.

Verification
REQ-031 SHALL cover reset: nrst low 2 cycles with all buttons high -> state = 0, clear = 1, no lap or clk_div after release.
REQ-032 SHALL cover the add limit: start, then 25 add edges in SET -> exactly 20 lap pulses; start -> RUN.
REQ-033 SHALL cover countdown with CLK_HZ = 10: in RUN, clk_div pulses every 10th cycle; time_up = 1 -> DONE next cycle, alarm high for 30 cycles, then low.
REQ-034 SHALL cover pause with TIMER_CTRL_PAUSE_EN, CLK_HZ = 10:
- Pause at prescaler = 4, 50 idle cycles, resume.
- Required: the next clk_div comes 6 cycles after resume, with none while paused.
REQ-035 SHALL cover collisions:
- rst_btn and time_up edges in the same RUN cycle -> IDLE, alarm = 0.
- Start in SET with add_count = 0 -> stays in SET.

Source files
------------

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Sequencing controller for a countdown timer: arms a round (IDLE), collects
// +30 s lap pulses (SET), strobes the countdown at 1 Hz (RUN), optionally
// pauses (PAUSE) and raises an alarm after expiry (DONE).
//
// Build option:
//   TIMER_CTRL_PAUSE_EN  defined   -> pause_btn port and PAUSE state exist
//                        undefined -> no pause_btn, code 3 is illegal
//
// Ports:
//   clk         in   system clock, rising edge
//   nrst        in   synchronous active-low reset
//   start_btn   in   start / confirm button (synchronized)
//   add_btn     in   add-time button (synchronized)
//   pause_btn   in   pause / resume button (synchronized, option only)
//   rst_btn     in   abort-round button (synchronized)
//   time_up     in   expiry flag from the countdown timer
//   enable_dec  out  countdown enable level
//   enable_in   out  increment enable level
//   clk_div     out  one-cycle 1 Hz decrement strobe
//   lap         out  one-cycle add-30 pulse
//   clear       out  timer clear level
//   state       out  current FSM state code
//   alarm       out  expiry alarm level
//
// state | meaning
// ------+-----------------------------------------------
// 0 IDLE  | timer cleared, waiting for start
// 1 SET   | accepting add presses (up to MAX_ADDS)
// 2 RUN   | counting down, 1 Hz strobe active
// 3 PAUSE | countdown frozen, prescaler held
// 4 DONE  | expired, alarm for ALARM_SECS seconds
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int CLK_HZ     = 10000000,
    parameter int MAX_ADDS   = 20,
    parameter int ALARM_SECS = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_btn,
    input  logic       add_btn,
`ifdef TIMER_CTRL_PAUSE_EN
    input  logic       pause_btn,
`endif
    input  logic       rst_btn,
    input  logic       time_up,
    output logic       enable_dec,
    output logic       enable_in,
    output logic       clk_div,
    output logic       lap,
    output logic       clear,
    output logic [2:0] state,
    output logic       alarm
);

    localparam int PW  = (CLK_HZ > 1)     ? $clog2(CLK_HZ)       : 1;
    localparam int AW  = (MAX_ADDS > 0)   ? $clog2(MAX_ADDS + 1) : 1;
    localparam int ALW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

    localparam logic [PW-1:0]  PRE_TC  = PW'(CLK_HZ - 1);
    localparam logic [AW-1:0]  ADD_MAX = AW'(MAX_ADDS);
    localparam logic [ALW-1:0] ALM_MAX = ALW'(ALARM_SECS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [AW-1:0]  r_add_cnt;
    logic [PW-1:0]  r_presc;
    logic [ALW-1:0] r_alm_cnt;

    // r_armed masks the first cycle after reset so a button held through
    // reset release is not seen as a fresh press.
    logic r_armed;
    logic r_start_q, r_add_q, r_rst_q;
    logic w_start_e, w_add_e, w_rst_e;
`ifdef TIMER_CTRL_PAUSE_EN
    logic r_pause_q;
    logic w_pause_e;
    assign w_pause_e = r_armed & pause_btn & ~r_pause_q;
`endif

    assign w_start_e = r_armed & start_btn & ~r_start_q;
    assign w_add_e   = r_armed & add_btn   & ~r_add_q;
    assign w_rst_e   = r_armed & rst_btn   & ~r_rst_q;

    logic w_clear, w_en_in, w_en_dec, w_lap, w_clk_div, w_alarm;
    logic r_clear, r_en_in, r_en_dec, r_lap, r_clk_div, r_alarm;

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: rst_btn > time_up > pause > start/add
    always_comb begin
        w_next = r_state;
        if (w_rst_e) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_e) w_next = S_SET;
                S_SET:   if (w_start_e && (r_add_cnt != '0)) w_next = S_RUN;
                S_RUN: begin
                    if (time_up) w_next = S_DONE;
`ifdef TIMER_CTRL_PAUSE_EN
                    else if (w_pause_e) w_next = S_PAUSE;
`endif
                end
`ifdef TIMER_CTRL_PAUSE_EN
                S_PAUSE: if (w_pause_e) w_next = S_RUN;
`endif
                S_DONE:  if (w_start_e) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output logic (registered below)
    always_comb begin
        w_clear   = (r_state == S_IDLE);
        w_en_in   = (r_state == S_SET);
        w_en_dec  = (r_state == S_RUN);
        // Start wins over add when both land in the same SET cycle.
        w_lap     = (r_state == S_SET) && (w_next == S_SET) && w_add_e &&
                    (r_add_cnt < ADD_MAX);
        // No strobe in the cycle RUN is left.
        w_clk_div = (r_state == S_RUN) && (w_next == S_RUN) &&
                    (r_presc == PRE_TC);
        w_alarm   = (r_state == S_DONE) && (w_next == S_DONE) &&
                    (r_alm_cnt < ALM_MAX);
    end

    // Edge history, counters and output registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_armed   <= 1'b0;
            r_start_q <= 1'b0;
            r_add_q   <= 1'b0;
            r_rst_q   <= 1'b0;
`ifdef TIMER_CTRL_PAUSE_EN
            r_pause_q <= 1'b0;
`endif
            r_add_cnt <= '0;
            r_presc   <= '0;
            r_alm_cnt <= '0;
            r_clear   <= 1'b1;
            r_en_in   <= 1'b0;
            r_en_dec  <= 1'b0;
            r_lap     <= 1'b0;
            r_clk_div <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_start_q <= start_btn;
            r_add_q   <= add_btn;
            r_rst_q   <= rst_btn;
`ifdef TIMER_CTRL_PAUSE_EN
            r_pause_q <= pause_btn;
`endif
            if ((r_state == S_IDLE) || (w_next == S_IDLE))
                r_add_cnt <= '0;
            else if (w_lap)
                r_add_cnt <= r_add_cnt + AW'(1);

            // Prescaler holds through PAUSE and on the RUN->PAUSE cycle so
            // resume continues the interrupted second.
            if (w_rst_e ||
                ((r_state == S_SET) && (w_next == S_RUN)) ||
                ((r_state != S_DONE) && (w_next == S_DONE)))
                r_presc <= '0;
            else if (((r_state == S_RUN)  && (w_next == S_RUN)) ||
                     ((r_state == S_DONE) && (w_next == S_DONE)))
                r_presc <= (r_presc == PRE_TC) ? '0 : r_presc + PW'(1);

            if ((r_state != S_DONE) || (w_next != S_DONE))
                r_alm_cnt <= '0;
            else if ((r_presc == PRE_TC) && (r_alm_cnt < ALM_MAX))
                r_alm_cnt <= r_alm_cnt + ALW'(1);

            r_clear   <= w_clear;
            r_en_in   <= w_en_in;
            r_en_dec  <= w_en_dec;
            r_lap     <= w_lap;
            r_clk_div <= w_clk_div;
            r_alarm   <= w_alarm;
        end
    end

    assign state      = r_state;
    assign clear      = r_clear;
    assign enable_in  = r_en_in;
    assign enable_dec = r_en_dec;
    assign lap        = r_lap;
    assign clk_div    = r_clk_div;
    assign alarm      = r_alarm;

endmodule
